miter_key_sweep: RTL

- Sequential stimulus/evaluation controller directly upstream and downstream of the lock-verification miter (original vs. encrypted circuit, per-output equality `Q`, overall `Z`).
- Latches one candidate key and drives it to the miter's key input.
- Exhaustively sweeps every primary-input pattern, samples `Q`/`Z` after a settle delay, and reports mismatch statistics plus a key-correct verdict.
- Used by the locking flow to confirm a key, or to grade wrong keys by output corruption.

---
 rtl/miter_key_sweep.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/miter_key_sweep.sv
// Key-sweep controller around the lock-verification miter: latches a key, walks every input
// pattern, and grades the key by miter mismatches. Optional: MITER_SWEEP_EARLY_STOP_EN.
module miter_key_sweep #(
   parameter int unsigned NIN    = 5,
   parameter int unsigned NKEY   = 10,
   parameter int unsigned NOUT   = 2,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNTW   = 8
) (
   input  logic            C,
   input  logic            R,
   input  logic            start,
   input  logic            abort,
   input  logic [NKEY-1:0] key_in,
   output logic [NIN-1:0]  pat_out,
   output logic [NKEY-1:0] key_out,
   input  logic [NOUT-1:0] q_in,
   input  logic            z_in,
   output logic            busy,
   output logic            done,
   output logic            key_ok,
   output logic [CNTW-1:0] err_cnt,
   output logic [NOUT-1:0] out_fail,
   output logic [NIN-1:0]  first_fail_pat,
   output logic            first_fail_vld
);

   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SAMPLE, ST_DONE} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [NIN-1:0]  pat_q, pat_d;
   logic [NKEY-1:0] key_q, key_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ok_q, ok_d;
   logic [CNTW-1:0] err_q, err_d;
   logic [NOUT-1:0] of_q, of_d;
   logic [NIN-1:0]  ffp_q, ffp_d;
   logic            ffv_q, ffv_d;
   logic            last_pat_c;
   logic            stop_c;

   assign last_pat_c = (pat_q == {NIN{1'b1}});
`ifdef MITER_SWEEP_EARLY_STOP_EN
   assign stop_c = last_pat_c | ~z_in;
`else
   assign stop_c = last_pat_c;
`endif

   always_ff @(posedge C or negedge R) begin
      if (!R) state_q <= ST_IDLE;
      else    state_q <= state_d;
   end

   // Next-state: abort pre-empts both settling and sampling.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (abort)                    state_d = ST_IDLE;
            else if (cnt_q <= SW'(1))     state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (abort)       state_d = ST_IDLE;
            else if (stop_c) state_d = ST_DONE;
            else             state_d = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      pat_d  = pat_q;
      key_d  = key_q;
      done_d = 1'b0;
      ok_d   = ok_q;
      err_d  = err_q;
      of_d   = of_q;
      ffp_d  = ffp_q;
      ffv_d  = ffv_q;
      busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d = key_in;
               pat_d = '0;
               err_d = '0;
               of_d  = '0;
               ffv_d = 1'b0;
               ok_d  = 1'b0;
               cnt_d = SW'(SETTLE);
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - SW'(1);
            if (abort) ok_d = 1'b0;
         end
         ST_SAMPLE: begin
            if (abort) begin
               ok_d = 1'b0;
            end else begin
               if (!z_in) begin
                  if (err_q != {CNTW{1'b1}}) err_d = err_q + CNTW'(1);
                  if (!ffv_q) begin
                     ffp_d = pat_q;
                     ffv_d = 1'b1;
                  end
               end
               of_d = of_q | ~q_in;
               if (!stop_c) begin
                  pat_d = pat_q + NIN'(1);
                  cnt_d = SW'(SETTLE);
               end
            end
         end
         default: ;
      endcase
      // Verdict includes the final sample's contribution.
      if (state_q == ST_SAMPLE && state_d == ST_DONE) begin
         done_d = 1'b1;
         ok_d   = (err_d == '0) && (of_d == '0);
      end
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         cnt_q  <= '0;
         pat_q  <= '0;
         key_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ok_q   <= 1'b0;
         err_q  <= '0;
         of_q   <= '0;
         ffp_q  <= '0;
         ffv_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pat_q  <= pat_d;
         key_q  <= key_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
         of_q   <= of_d;
         ffp_q  <= ffp_d;
         ffv_q  <= ffv_d;
      end
   end

   assign pat_out        = pat_q;
   assign key_out        = key_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign key_ok         = ok_q;
   assign err_cnt        = err_q;
   assign out_fail       = of_q;
   assign first_fail_pat = ffp_q;
   assign first_fail_vld = ffv_q;

endmodule
